// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan
// Brief    : Four-digit multiplexed 7-segment scanner. A whole frame
//            (patterns, decimal points, brightness) is latched once per scan.
//            Each digit slot opens with a blanking gap to suppress ghosting.
// Options  : SEG7_DIM_EN - enables 3-bit PWM dimming of seg/dp during the ON
//            window. The brightness level is latched with the frame.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan #(
    parameter int DIGIT_TICKS    = 27000,
    parameter int BLANK_TICKS    = 270,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [27:0] display_in,
    input  logic [3:0]  dp_in,
    input  logic [2:0]  brightness,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int              CNT_W       = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] c_cnt_blank = CNT_W'(BLANK_TICKS);
    // Inactive output levels; XOR-ing a logical "lit/selected" value with these
    // applies the physical polarity.
    localparam logic [6:0]       c_seg_off   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic             c_dp_off    = (SEG_ACTIVE_LOW != 0);
    localparam logic [3:0]       c_an_off    = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [27:0]      snap_q, snap_d;
    logic [3:0]       snap_dp_q, snap_dp_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       an_q, an_d;
    logic             frame_tick_q, frame_tick_d;
    logic [6:0]       lit_seg;
    logic             lit_dp;
    logic [3:0]       lit_an;
    logic             load_frame;

`ifdef SEG7_DIM_EN
    logic [2:0]       bright_q, bright_d;
    logic [2:0]       pwm_q, pwm_d;
`else
    logic             unused_brightness;
    assign unused_brightness = ^brightness;
`endif

    // Next-state, frame snapshot and registered-output decode. Outputs are
    // decoded from the next state so the output flops line up with it.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        snap_dp_d    = snap_dp_q;
        frame_tick_d = 1'b0;
        load_frame   = 1'b0;
        lit_seg      = 7'h00;
        lit_dp       = 1'b0;
        lit_an       = 4'h0;
`ifdef SEG7_DIM_EN
        bright_d     = bright_q;
        pwm_d        = 3'd0;
`endif

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = 2'd0;
        end else if (state_q == ST_IDLE) begin
            state_d    = ST_BLANK;
            cnt_d      = '0;
            idx_d      = 2'd0;
            load_frame = 1'b1;
        end else begin
            if (cnt_q == c_cnt_last) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
                // Wrap from the last digit back to digit 0 starts a new frame.
                if (idx_q == 2'd3) begin
                    load_frame = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            state_d = (cnt_d < c_cnt_blank) ? ST_BLANK : ST_ON;
        end

        if (load_frame) begin
            snap_d       = display_in;
            snap_dp_d    = dp_in;
            frame_tick_d = 1'b1;
`ifdef SEG7_DIM_EN
            bright_d     = brightness;
`endif
        end

        if (state_d == ST_ON) begin
            lit_an[idx_d] = 1'b1;
            lit_dp        = snap_dp_d[idx_d];
            case (idx_d)
                2'd0:    lit_seg = snap_d[6:0];
                2'd1:    lit_seg = snap_d[13:7];
                2'd2:    lit_seg = snap_d[20:14];
                default: lit_seg = snap_d[27:21];
            endcase
`ifdef SEG7_DIM_EN
            // PWM restarts at 0 on every entry into the ON window.
            pwm_d = (state_q == ST_ON) ? (pwm_q + 3'd1) : 3'd0;
            if (pwm_d > bright_d) begin
                lit_seg = 7'h00;
                lit_dp  = 1'b0;
            end
`endif
        end

        seg_d = lit_seg ^ c_seg_off;
        dp_d  = lit_dp ^ c_dp_off;
        an_d  = lit_an ^ c_an_off;
    end

    // State, counters, snapshot and output registers with async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            snap_q       <= 28'h0;
            snap_dp_q    <= 4'h0;
            seg_q        <= c_seg_off;
            dp_q         <= c_dp_off;
            an_q         <= c_an_off;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            snap_dp_q    <= snap_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

`ifdef SEG7_DIM_EN
    // Brightness snapshot and PWM phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_q <= 3'd0;
            pwm_q    <= 3'd0;
        end else begin
            bright_q <= bright_d;
            pwm_q    <= pwm_d;
        end
    end
`endif

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
